dac_dma_prefill_buffer: RTL and testbench



---
 rtl/dac_dma_buffer_pkg.sv | 18 +
 rtl/dac_dma_buffer_mem.sv | 25 ++
 rtl/dac_dma_prefill_buffer.sv | 115 +++++++++++
 tb/tb_dac_dma_prefill_buffer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dac_dma_buffer_pkg.sv
// Shared types and constants for the DAC DMA prefill buffer.
package dac_dma_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned SAMPLE_W                = 16;
  localparam int unsigned DEFAULT_FIFO_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_FIFO_DEPTH      = 1 << DEFAULT_FIFO_ADDR_WIDTH;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/dac_dma_buffer_mem.sv
// Simple dual-port beat store: synchronous write, registered read, no reset on storage.
module dac_dma_buffer_mem #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dac_dma_prefill_buffer.sv
// DMA-to-DAC beat buffer: holds off playback until START_LEVEL beats are queued,
// then serves one beat per dac_valid, substituting zeros and flagging dac_dunf when dry.
module dac_dma_prefill_buffer
  import dac_dma_buffer_pkg::*;
#(
  parameter int NUM_CHANNELS    = 1,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int FIFO_ADDR_WIDTH = 5,
  parameter int START_LEVEL     = 16
) (
  input  logic                                          dac_clk,
  input  logic                                          dac_rst,
  input  logic [NUM_CHANNELS-1:0]                       dac_enable,
  input  logic [NUM_CHANNELS-1:0]                       dac_valid,
  output logic [DATA_PATH_WIDTH*NUM_CHANNELS*16-1:0]    dac_ddata,
  output logic                                          dac_dunf,
  input  logic                                          s_axis_valid,
  output logic                                          s_axis_ready,
  input  logic [DATA_PATH_WIDTH*NUM_CHANNELS*16-1:0]    s_axis_data,
  output logic [FIFO_ADDR_WIDTH:0]                      fifo_level
);

  localparam int DW    = DATA_PATH_WIDTH * NUM_CHANNELS * SAMPLE_W;
  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int LW    = FIFO_ADDR_WIDTH + 1;
  localparam int DEPTH = int'(fifo_depth(FIFO_ADDR_WIDTH));

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          dunf_q, dunf_d;
  logic          mem_sel_q, mem_sel_d;
  logic          push, pop, flush, wr_en;
  logic [DW-1:0] rd_data;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dunf_d    = 1'b0;
    mem_sel_d = mem_sel_q;
    pop       = 1'b0;

    s_axis_ready = (state_q != IDLE) && (level_q < LW'(DEPTH));
    push         = s_axis_valid && s_axis_ready;
    flush        = !(|dac_enable) || (state_q == IDLE);

    unique case (state_q)
      IDLE: state_d = FILL;
      FILL: if (level_q >= LW'(START_LEVEL)) state_d = RUN;
      RUN: begin
        if (|dac_valid) begin
          if (level_q != '0) begin
            pop       = 1'b1;
            mem_sel_d = 1'b1;
          end else begin
            mem_sel_d = 1'b0;
            dunf_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);

    // Disable (or sitting in IDLE) flushes everything, including a push racing the drop.
    if (flush) begin
      if (!(|dac_enable)) state_d = IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      dunf_d    = 1'b0;
      mem_sel_d = 1'b0;
      pop       = 1'b0;
    end
    wr_en = push && !flush;
  end

  always_ff @(posedge dac_clk or posedge dac_rst) begin
    if (dac_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      dunf_q    <= 1'b0;
      mem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      dunf_q    <= dunf_d;
      mem_sel_q <= mem_sel_d;
    end
  end

  dac_dma_buffer_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk       (dac_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (s_axis_data),
    .rd_en_i   (pop),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // The memory read register doubles as the output register; mem_sel_q masks it to zero.
  assign dac_ddata  = mem_sel_q ? rd_data : '0;
  assign dac_dunf   = dunf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_dac_dma_prefill_buffer.sv
// Directed + randomized bench for dac_dma_prefill_buffer against a queue-based reference.
module tb_dac_dma_prefill_buffer;

  localparam int NCH   = 1;
  localparam int DPW   = 4;
  localparam int AW    = 5;
  localparam int START = 16;
  localparam int DW    = DPW * NCH * 16;
  localparam int DEPTH = 1 << AW;

  logic           dac_clk, dac_rst;
  logic [NCH-1:0] dac_enable, dac_valid;
  logic [DW-1:0]  dac_ddata, s_axis_data;
  logic           dac_dunf, s_axis_valid, s_axis_ready;
  logic [AW:0]    fifo_level;

  dac_dma_prefill_buffer #(
    .NUM_CHANNELS(NCH), .DATA_PATH_WIDTH(DPW), .FIFO_ADDR_WIDTH(AW), .START_LEVEL(START)
  ) dut (
    .dac_clk(dac_clk), .dac_rst(dac_rst), .dac_enable(dac_enable), .dac_valid(dac_valid),
    .dac_ddata(dac_ddata), .dac_dunf(dac_dunf), .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready), .s_axis_data(s_axis_data), .fifo_level(fifo_level)
  );

  initial dac_clk = 1'b0;
  always #5 dac_clk = ~dac_clk;

  int checks = 0;
  int errors = 0;

  // Reference: mode 0=idle 1=prefilling 2=playing; queue holds the buffered beats.
  int            m_mode;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_ddata;
  logic          m_dunf;
  logic [DW-1:0] cur_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode  = 0;
    m_ddata = '0;
    m_dunf  = 1'b0;
  endtask

  // Called just after a negedge; applies inputs for one clock and checks both sides of the edge.
  task automatic cycle(input logic en, input logic vld, input logic sv);
    logic exp_ready, pushed;
    int   pre_size;
    dac_enable   = {NCH{en}};
    dac_valid    = {NCH{vld}};
    s_axis_valid = sv;
    s_axis_data  = cur_data;
    #1;
    pre_size  = q.size();
    exp_ready = (m_mode != 0) && (pre_size < DEPTH);
    chk("ready", 64'(s_axis_ready), 64'(exp_ready));
    chk("level_pre", 64'(fifo_level), 64'(pre_size));
    pushed = sv && exp_ready;
    @(posedge dac_clk);
    if (!en) begin
      model_reset();
    end else begin
      m_dunf = 1'b0;
      if (m_mode == 2 && vld) begin
        if (q.size() > 0) m_ddata = q.pop_front();
        else begin m_ddata = '0; m_dunf = 1'b1; end
      end
      if (pushed) q.push_back(cur_data);
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && pre_size >= START) m_mode = 2;
    end
    if (pushed) cur_data = {$urandom, $urandom};
    #1;
    chk("ddata", 64'(dac_ddata), 64'(m_ddata));
    chk("dunf", 64'(dac_dunf), 64'(m_dunf));
    chk("level_post", 64'(fifo_level), 64'(q.size()));
    @(negedge dac_clk);
  endtask

  task automatic run(input int n, input logic en, input logic vld, input logic sv);
    for (int i = 0; i < n; i++) cycle(en, vld, sv);
  endtask

  initial begin
    int guard;
    dac_rst = 1'b1; dac_enable = '0; dac_valid = '0;
    s_axis_valid = 1'b0; s_axis_data = '0;
    cur_data = {$urandom, $urandom};
    model_reset();
    @(negedge dac_clk); @(negedge dac_clk);
    chk("rst_ddata", 64'(dac_ddata), 64'd0);
    chk("rst_dunf", 64'(dac_dunf), 64'd0);
    chk("rst_ready", 64'(s_axis_ready), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    dac_rst = 1'b0;
    run(2, 1'b0, 1'b0, 1'b0);

    // Prefill at full rate with the DAC asking for data throughout.
    run(24, 1'b1, 1'b1, 1'b1);

    // Back-pressure to full, then one read frees exactly one slot.
    run(40, 1'b1, 1'b0, 1'b1);
    chk("full_level", 64'(fifo_level), 64'(DEPTH));
    chk("full_ready", 64'(s_axis_ready), 64'd0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("free_level", 64'(fifo_level), 64'(DEPTH - 1));
    chk("free_ready", 64'(s_axis_ready), 64'd1);

    // Drain to two beats, then underflow twice.
    guard = 0;
    while (q.size() > 2 && guard < 100) begin cycle(1'b1, 1'b1, 1'b0); guard++; end
    chk("drain_to_two", 64'(q.size()), 64'd2);
    run(4, 1'b1, 1'b1, 1'b0);
    chk("uf_dunf", 64'(dac_dunf), 64'd1);
    cur_data = {8{8'hA5}};
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    chk("a5_data", 64'(dac_ddata), {8{8'hA5}});
    chk("a5_dunf", 64'(dac_dunf), 64'd0);

    // Simultaneous push and pop on empty.
    cycle(1'b1, 1'b1, 1'b1);
    chk("sim_dunf", 64'(dac_dunf), 64'd1);
    chk("sim_level", 64'(fifo_level), 64'd1);
    cycle(1'b1, 1'b1, 1'b0);

    // Enable drop at level 10 with a push racing it.
    guard = 0;
    while (q.size() < 10 && guard < 100) begin cycle(1'b1, 1'b0, 1'b1); guard++; end
    cycle(1'b0, 1'b0, 1'b1);
    chk("drop_level", 64'(fifo_level), 64'd0);
    chk("drop_ready", 64'(s_axis_ready), 64'd0);
    chk("drop_ddata", 64'(dac_ddata), 64'd0);
    run(6, 1'b1, 1'b1, 1'b1);

    // Randomized traffic with occasional enable drops.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 59) != 0, 1'($urandom), $urandom_range(0, 3) != 0);

    // Async reset between edges while playing.
    run(25, 1'b1, 1'b0, 1'b1);
    run(3, 1'b1, 1'b1, 1'b1);
    #2 dac_rst = 1'b1;
    #1;
    chk("arst_ddata", 64'(dac_ddata), 64'd0);
    chk("arst_dunf", 64'(dac_dunf), 64'd0);
    chk("arst_ready", 64'(s_axis_ready), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    model_reset();
    @(negedge dac_clk);
    dac_rst = 1'b0;
    run(24, 1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
